membus_master: RTL and testbench
================================

MEMBUS_MASTER -- requirements
Module: membus_master

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16'd5000: cycles rq_cyc may wait for addr_ack before NXM.
REQ-002 Parameter RD_TIMEOUT, default 16'd5000: cycles after addr_ack to wait for rd_rs before NXM.
REQ-003 Parameter RD_SETTLE, default 4: cycles data keeps accumulating after rd_rs.
REQ-004 Parameter WR_SETUP, default 2: cycles write data is held on mb_out before wr_rs.
REQ-005 clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-006 cmd_start  in  1  one-cycle command pulse; cmd_rd  in  1  read requested; cmd_wr  in  1  write requested (both set = read-modify-write).
REQ-007 cmd_addr  in  18 [18:35]  word address; cmd_wdata  in  36 [0:35]  write data; cmd_wr_go  in  1  RMW write-half pulse; fmc_en  in  1  fast memory present.
REQ-008 busy  out  1; rd_valid  out  1  one-cycle pulse; rd_data  out  36 [0:35]; done  out  1  one-cycle pulse; nxm  out  1  one-cycle timeout pulse.
REQ-009 membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs  out  1 each; membus_sel  out  4 [18:21]; membus_ma  out  15 [21:35]; membus_fmc_select  out  1; membus_mb_out  out  36 [0:35].
REQ-010 membus_addr_ack  in  1; membus_rd_rs  in  1; membus_mb_in  in  36 [0:35]  data from memory.

Function
REQ-011 States: IDLE, REQ, RD_WAIT, RD_HOLD, RMW_WAIT, WR_DATA, WR_RS, DONE; all outputs registered; busy = (state != IDLE).
REQ-012 IDLE: cmd_start with cmd_rd|cmd_wr latches addr, wdata, rd, wr, clears rd_data, enters REQ next cycle; cmd_start with neither, or while busy, is ignored.
REQ-013 REQ: rq_cyc=1, rd_rq=rd, wr_rq=wr, sel=addr[18:21], ma=addr[21:35], fmc_select=fmc_en & (addr[18:31]==0); 16-bit counter starts at 0.
REQ-014 REQ: addr_ack sampled high -> rq_cyc, rd_rq, wr_rq, sel, ma, fmc_select go 0 next cycle; next state RD_WAIT if rd else WR_DATA.
REQ-015 REQ: counter reaching ACK_TIMEOUT without ack -> nxm pulse, all membus outputs 0, IDLE; ack in the timeout cycle wins.
REQ-016 RD_WAIT and RD_HOLD: rd_data <= rd_data | membus_mb_in every cycle (memory data is pulsed, not levelled).
REQ-017 RD_WAIT: rd_rs -> RD_HOLD; counter reaching RD_TIMEOUT -> nxm, IDLE, no rd_valid.
REQ-018 RD_HOLD: after RD_SETTLE cycles, rd_valid pulses one cycle with final rd_data; next RMW_WAIT if wr else DONE.
REQ-019 RMW_WAIT: no timeout; cmd_wr_go latches cmd_wdata, enters WR_DATA; cmd_start ignored.
REQ-020 WR_DATA: membus_mb_out = wdata for WR_SETUP cycles, then WR_RS.
REQ-021 WR_RS: membus_wr_rs=1 exactly one cycle, mb_out still wdata; next DONE.
REQ-022 DONE: mb_out=0, wr_rs=0, done pulses one cycle, IDLE next cycle; mb_out is 0 in every state except WR_DATA/WR_RS.
REQ-023 rd_rs or addr_ack outside their wait states are ignored; rd_data holds until the next accepted command.
REQ-024 Pure write issues no rd_valid; pure read never asserts wr_rs or mb_out.

Reset
REQ-025 reset asserted: immediately state=IDLE, counter=0, rd_data=0, every output 0, including mid-cycle (memory left paused is accepted).
REQ-026 First command is accepted on the first clk edge after reset deasserts.

Verification
REQ-027 Read: addr 0o000123, ack after 3 cycles, rd_rs with mb_in=0o123456701234 -> rd_valid with that word, done, wr_rs never high.
REQ-028 Write: wdata 0o777000777000 -> mb_out equals wdata for WR_SETUP+1 cycles, wr_rs one cycle in last, mb_out 0 after, done.
REQ-029 RMW: read returns 0o1, cmd_wr_go with 0o2 after 10 cycles -> rd_valid 0o1, rq_cyc low throughout wait, mb_out 0o2 then wr_rs, done.
REQ-030 NXM: no ack -> nxm exactly ACK_TIMEOUT cycles after rq_cyc rises, rq_cyc 0, busy 0, no done.
REQ-031 FMC: fmc_en=1, addr 0o000017 -> fmc_select 1; addr 0o000020 -> 0; fmc_en=0 -> always 0.
REQ-032 Reset mid RD_WAIT -> all outputs 0 before next clk edge; new read completes normally.

Source files
------------

// File: rtl/membus_master_if.sv
// Memory bus connection between a membus master and a memory module.
// Handshake: the master holds membus_rq_cyc (with rd_rq/wr_rq, sel, ma,
// fmc_select) steady until it samples membus_addr_ack high, then drops them
// on the next cycle. For reads, membus_rd_rs marks that membus_mb_in carries
// data; the data is pulsed, so the master ORs it in over a settle window.
// For writes, membus_mb_out is held before and during the one-cycle
// membus_wr_rs strobe. Bit numbering follows the machine: bit 0 is the MSB.
interface membus_master_if;
  logic         membus_rq_cyc;
  logic         membus_rd_rq;
  logic         membus_wr_rq;
  logic         membus_wr_rs;
  logic [18:21] membus_sel;
  logic [21:35] membus_ma;
  logic         membus_fmc_select;
  logic [0:35]  membus_mb_out;
  logic         membus_addr_ack;
  logic         membus_rd_rs;
  logic [0:35]  membus_mb_in;

  modport master (
    output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
    output membus_sel, membus_ma, membus_fmc_select, membus_mb_out,
    input  membus_addr_ack, membus_rd_rs, membus_mb_in
  );

  modport slave (
    input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_wr_rs,
    input  membus_sel, membus_ma, membus_fmc_select, membus_mb_out,
    output membus_addr_ack, membus_rd_rs, membus_mb_in
  );
endinterface

// File: rtl/membus_master.sv
// Membus master: runs one read, write or read-modify-write cycle per command,
// with address-acknowledge and read-restart timeouts reported as nxm.
// Every output is a flop; bus outputs are decoded from the next state.
module membus_master #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd5000,
  parameter logic [15:0] RD_TIMEOUT  = 16'd5000,
  parameter int unsigned RD_SETTLE   = 4,
  parameter int unsigned WR_SETUP    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic         cmd_rd,
  input  logic         cmd_wr,
  input  logic [18:35] cmd_addr,
  input  logic [0:35]  cmd_wdata,
  input  logic         cmd_wr_go,
  input  logic         fmc_en,
  output logic         busy,
  output logic         rd_valid,
  output logic [0:35]  rd_data,
  output logic         done,
  output logic         nxm,
  output logic [2:0]   dbg_state,
  membus_master_if.master mb
);

  typedef enum logic [2:0] {
    IDLE, REQ, RD_WAIT, RD_HOLD, RMW_WAIT, WR_DATA, WR_RS, DONE
  } state_e;

  localparam logic [16:0] ACK_LIM    = {1'b0, ACK_TIMEOUT};
  localparam logic [16:0] RD_LIM     = {1'b0, RD_TIMEOUT};
  localparam logic [16:0] SETTLE_LIM = 17'(RD_SETTLE);
  localparam logic [16:0] SETUP_LIM  = 17'(WR_SETUP);

  state_e       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [16:0]  cnt_nxt;
  logic [18:35] addr_q, addr_d;
  logic [0:35]  wdata_q, wdata_d;
  logic         rd_q, rd_d, wr_q, wr_d;
  logic [0:35]  rd_data_q, rd_data_d;
  logic         busy_q, busy_d, rd_valid_q, rd_valid_d;
  logic         done_q, done_d, nxm_q, nxm_d;
  logic         rq_cyc_q, rq_cyc_d, rd_rq_q, rd_rq_d, wr_rq_q, wr_rq_d;
  logic         wr_rs_q, wr_rs_d, fmc_q, fmc_d;
  logic [18:21] sel_q, sel_d;
  logic [21:35] ma_q, ma_d;
  logic [0:35]  mb_out_q, mb_out_d;

  // One shared counter times the ack wait, read wait, settle and setup phases.
  assign cnt_nxt = {1'b0, cnt_q} + 17'd1;

  // Next-state, command latches, read accumulation and the one-cycle pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    nxm_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_start && (cmd_rd || cmd_wr)) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          rd_d      = cmd_rd;
          wr_d      = cmd_wr;
          rd_data_d = '0;
          cnt_d     = '0;
          state_d   = REQ;
        end
      end
      REQ: begin
        // An ack arriving in the timeout cycle still wins.
        if (mb.membus_addr_ack) begin
          cnt_d   = '0;
          state_d = rd_q ? RD_WAIT : WR_DATA;
        end else if (cnt_nxt == ACK_LIM) begin
          nxm_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_nxt[15:0];
        end
      end
      RD_WAIT: begin
        rd_data_d = rd_data_q | mb.membus_mb_in;
        if (mb.membus_rd_rs) begin
          cnt_d   = '0;
          state_d = RD_HOLD;
        end else if (cnt_nxt == RD_LIM) begin
          nxm_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_nxt[15:0];
        end
      end
      RD_HOLD: begin
        rd_data_d = rd_data_q | mb.membus_mb_in;
        if (cnt_nxt == SETTLE_LIM) begin
          rd_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = wr_q ? RMW_WAIT : DONE;
        end else begin
          cnt_d = cnt_nxt[15:0];
        end
      end
      RMW_WAIT: begin
        if (cmd_wr_go) begin
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (cnt_nxt == SETUP_LIM) begin
          cnt_d   = '0;
          state_d = WR_RS;
        end else begin
          cnt_d = cnt_nxt[15:0];
        end
      end
      WR_RS:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and status outputs decoded from the state being entered.
  always_comb begin
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    rq_cyc_d = (state_d == REQ);
    rd_rq_d  = rq_cyc_d & rd_d;
    wr_rq_d  = rq_cyc_d & wr_d;
    sel_d    = rq_cyc_d ? addr_d[18:21] : '0;
    ma_d     = rq_cyc_d ? addr_d[21:35] : '0;
    fmc_d    = rq_cyc_d & fmc_en & (addr_d[18:31] == 14'd0);
    wr_rs_d  = (state_d == WR_RS);
    mb_out_d = ((state_d == WR_DATA) || (state_d == WR_RS)) ? wdata_d : '0;
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      nxm_q      <= 1'b0;
      rq_cyc_q   <= 1'b0;
      rd_rq_q    <= 1'b0;
      wr_rq_q    <= 1'b0;
      wr_rs_q    <= 1'b0;
      sel_q      <= '0;
      ma_q       <= '0;
      fmc_q      <= 1'b0;
      mb_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      nxm_q      <= nxm_d;
      rq_cyc_q   <= rq_cyc_d;
      rd_rq_q    <= rd_rq_d;
      wr_rq_q    <= wr_rq_d;
      wr_rs_q    <= wr_rs_d;
      sel_q      <= sel_d;
      ma_q       <= ma_d;
      fmc_q      <= fmc_d;
      mb_out_q   <= mb_out_d;
    end
  end

  assign busy                 = busy_q;
  assign rd_valid             = rd_valid_q;
  assign rd_data              = rd_data_q;
  assign done                 = done_q;
  assign nxm                  = nxm_q;
  assign dbg_state            = state_q;
  assign mb.membus_rq_cyc     = rq_cyc_q;
  assign mb.membus_rd_rq      = rd_rq_q;
  assign mb.membus_wr_rq      = wr_rq_q;
  assign mb.membus_wr_rs      = wr_rs_q;
  assign mb.membus_sel        = sel_q;
  assign mb.membus_ma         = ma_q;
  assign mb.membus_fmc_select = fmc_q;
  assign mb.membus_mb_out     = mb_out_q;

endmodule

// File: tb/tb_membus_master.sv
// Bench for membus_master: a per-cycle plan of inputs and expected outputs,
// built from transaction-level rules, checked on every falling edge.
module tb_membus_master;
  localparam int ACK_N  = 20;
  localparam int RD_N   = 25;
  localparam int SETTLE = 4;
  localparam int SETUP  = 2;
  localparam int N      = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_start, cmd_rd, cmd_wr, cmd_wr_go, fmc_en;
  logic [18:35] cmd_addr;
  logic [0:35]  cmd_wdata;
  logic         busy, rd_valid, done, nxm;
  logic [0:35]  rd_data;
  logic [2:0]   dbg_state;

  membus_master_if mb_if();

  membus_master #(
    .ACK_TIMEOUT(16'(ACK_N)), .RD_TIMEOUT(16'(RD_N)),
    .RD_SETTLE(SETTLE), .WR_SETUP(SETUP)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rd(cmd_rd),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_wr_go(cmd_wr_go), .fmc_en(fmc_en), .busy(busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .nxm(nxm), .dbg_state(dbg_state),
    .mb(mb_if)
  );

  // Clock / reset
  always #5 clk = ~clk;

  typedef struct {
    bit start, rd, wr, ack, rs, go, fmc;
    logic [17:0] addr;
    logic [35:0] wdata, mb_in;
  } stim_t;

  typedef struct {
    bit rq, rdq, wrq, wrs, fmc, busy, rv, dn, nx, chk_rd;
    logic [3:0]  sel;
    logic [14:0] ma;
    logic [35:0] mb_out, rd_data;
  } exp_t;

  stim_t       st[0:N+1];
  exp_t        ex[0:N+1];
  bit          rst_plan[0:N+1];
  logic [35:0] exp_q[$];
  int          cur_edge = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0o expected %0o", name, cur_edge, act, expv);
    end
  endtask

  // Model: lay out one transaction's inputs and the outputs the bus rules demand.
  task automatic plan_xfer(input int t0, input bit rd, input bit wr,
                           input logic [17:0] addr, input logic [35:0] wd,
                           input bit fmc, input int ack_dly, input int rs_dly,
                           input int go_dly, input logic [35:0] wd2,
                           input logic [35:0] rword);
    int ta, tr, tv, tw, tend, hold_from;
    bit acked;
    logic [35:0] data, acc;
    st[t0].start = 1; st[t0].rd = rd; st[t0].wr = wr;
    st[t0].addr = addr; st[t0].wdata = wd;
    ex[t0].chk_rd = 1; ex[t0].rd_data = '0;
    acked = (ack_dly > 0) && (ack_dly <= ACK_N);
    ta = acked ? t0 + ack_dly : t0 + ACK_N;
    for (int n = t0; n < ta; n++) begin
      st[n].fmc = fmc;
      ex[n].busy = 1; ex[n].rq = 1; ex[n].rdq = rd; ex[n].wrq = wr;
      ex[n].sel = 4'(addr >> 14);
      ex[n].ma = 15'(addr % 18'd32768);
      ex[n].fmc = fmc && (addr < 18'd16);
    end
    if (!acked) begin
      ex[ta].nx = 1;
      return;
    end
    st[ta].ack = 1;
    if (rd) begin
      if (!((rs_dly > 0) && (rs_dly <= RD_N))) begin
        for (int n = ta; n < ta + RD_N; n++) ex[n].busy = 1;
        ex[ta + RD_N].nx = 1;
        return;
      end
      tr = ta + rs_dly;
      tv = tr + SETTLE;
      st[tr].rs = 1;
      st[tr].mb_in = st[tr].mb_in | rword;
      acc = '0;
      for (int n = ta + 1; n <= tv; n++) acc = acc | st[n].mb_in;
      for (int n = ta; n <= tv; n++) ex[n].busy = 1;
      ex[tv].rv = 1;
      exp_q.push_back(acc);
      if (!wr) begin
        ex[tv].dn = 1;
        for (int n = tv; n <= tv + 3; n++) begin
          ex[n].chk_rd = 1; ex[n].rd_data = acc;
        end
        return;
      end
      tw = tv + go_dly;
      st[tw].go = 1; st[tw].wdata = wd2;
      data = wd2;
      for (int n = tv; n < tw; n++) ex[n].busy = 1;
      hold_from = tv;
    end else begin
      tw = ta; data = wd; acc = '0; hold_from = t0;
    end
    tend = tw + SETUP + 1;
    for (int n = tw; n <= tend; n++) begin
      ex[n].busy = 1;
      if (n < tend) ex[n].mb_out = data;
    end
    ex[tw + SETUP].wrs = 1;
    ex[tend].dn = 1;
    for (int n = hold_from; n <= tend; n++) begin
      ex[n].chk_rd = 1; ex[n].rd_data = acc;
    end
  endtask

  // Model: asynchronous reset at edge e clears everything before the next edge.
  task automatic plan_reset(input int e);
    rst_plan[e] = 1;
    for (int n = e; n <= N + 1; n++) ex[n] = '{default: '0};
    ex[e].chk_rd = 1;
  endtask

  // Driver: apply the inputs planned for edge n.
  task automatic apply(input int n);
    cmd_start = st[n].start; cmd_rd = st[n].rd; cmd_wr = st[n].wr;
    cmd_addr = st[n].addr; cmd_wdata = st[n].wdata; cmd_wr_go = st[n].go;
    fmc_en = st[n].fmc;
    mb_if.membus_addr_ack = st[n].ack;
    mb_if.membus_rd_rs = st[n].rs;
    mb_if.membus_mb_in = st[n].mb_in;
  endtask

  // Scoreboard: every output against the plan, plus hand-computed pins.
  task automatic check_cycle(input int e);
    chk("rq_cyc", 36'(mb_if.membus_rq_cyc), 36'(ex[e].rq));
    chk("rd_rq", 36'(mb_if.membus_rd_rq), 36'(ex[e].rdq));
    chk("wr_rq", 36'(mb_if.membus_wr_rq), 36'(ex[e].wrq));
    chk("wr_rs", 36'(mb_if.membus_wr_rs), 36'(ex[e].wrs));
    chk("sel", 36'(mb_if.membus_sel), 36'(ex[e].sel));
    chk("ma", 36'(mb_if.membus_ma), 36'(ex[e].ma));
    chk("fmc_select", 36'(mb_if.membus_fmc_select), 36'(ex[e].fmc));
    chk("mb_out", mb_if.membus_mb_out, ex[e].mb_out);
    chk("busy", 36'(busy), 36'(ex[e].busy));
    chk("rd_valid", 36'(rd_valid), 36'(ex[e].rv));
    chk("done", 36'(done), 36'(ex[e].dn));
    chk("nxm", 36'(nxm), 36'(ex[e].nx));
    if (ex[e].chk_rd) chk("rd_data", rd_data, ex[e].rd_data);
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_q edge %0d: got unexpected rd_valid data %0o expected none", e, rd_data);
      end else begin
        chk("rd_q", rd_data, exp_q.pop_front());
      end
    end
    case (e)
      2:   chk("pin_ma_read", 36'(mb_if.membus_ma), 36'o123);
      11:  chk("pin_rd_word", rd_data, 36'o123456701234);
      20:  chk("pin_fmc_17", 36'(mb_if.membus_fmc_select), 36'd1);
      39:  chk("pin_rd_accum", rd_data, 36'o400000770100);
      63:  chk("pin_rmw_mb_out", mb_if.membus_mb_out, 36'o2);
      70:  chk("pin_sel_nxm", 36'(mb_if.membus_sel), 36'd13);
      90:  chk("pin_nxm_ack", 36'(nxm), 36'd1);
      117: chk("pin_wr_rs_late_ack", 36'(mb_if.membus_wr_rs), 36'd1);
      151: chk("pin_nxm_rd", 36'(nxm), 36'd1);
      174: chk("pin_rd_after_rst", rd_data, 36'o777777777777);
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cur_edge >= 1 && cur_edge <= N) check_cycle(cur_edge);
    end
  end

  // Stimulus: directed transactions on fixed edges.
  initial begin
    for (int n = 0; n <= N + 1; n++) begin
      st[n] = '{default: '0};
      ex[n] = '{default: '0};
      rst_plan[n] = 0;
    end
    // Read right after reset; bus noise outside the read windows is ignored.
    st[5].mb_in = 36'o7;
    st[8].start = 1; st[8].rd = 1; st[8].addr = 18'o777777;
    st[12].mb_in = 36'o3;
    st[14].rs = 1; st[14].mb_in = 36'o777;
    st[15].ack = 1;
    st[16].start = 1; st[16].addr = 18'o5;
    plan_xfer(2, 1, 0, 18'o000123, '0, 1, 3, 2, 0, '0, 36'o123456701234);
    // Write to a fast-memory address.
    st[22].go = 1; st[22].wdata = 36'o555;
    plan_xfer(20, 0, 1, 18'o000017, 36'o777000777000, 1, 1, 0, 0, '0, '0);
    // Read accumulating pulsed data across the wait and settle window.
    st[32].mb_in = 36'o1;
    st[33].mb_in = 36'o100;
    st[39].mb_in = 36'o400000000000;
    st[40].mb_in = 36'o2;
    plan_xfer(30, 1, 0, 18'o000020, '0, 1, 2, 3, 0, '0, 36'o000000770000);
    // Read-modify-write with a long pause before the write half.
    st[55].start = 1; st[55].rd = 1; st[55].addr = 18'o777777; st[55].wdata = 36'o777;
    st[57].ack = 1;
    st[58].rs = 1; st[58].mb_in = 36'o70;
    plan_xfer(45, 1, 1, 18'o000200, '0, 1, 2, 1, 10, 36'o2, 36'o1);
    // No acknowledge: nxm.
    plan_xfer(70, 1, 0, 18'o654321, '0, 0, 0, 0, 0, '0, '0);
    // Acknowledge lands in the timeout cycle.
    plan_xfer(95, 0, 1, 18'o000017, 36'o123, 0, ACK_N, 0, 0, '0, '0);
    // Read restart never comes.
    st[130].mb_in = 36'o11;
    plan_xfer(125, 1, 0, 18'o000001, '0, 1, 1, 0, 0, '0, '0);
    // Reset in the middle of a read wait, then a fresh read.
    st[164].mb_in = 36'o55;
    plan_xfer(160, 1, 0, 18'o000002, '0, 1, 2, 0, 0, '0, '0);
    plan_reset(166);
    plan_xfer(168, 1, 0, 18'o000003, '0, 1, 1, 1, 0, '0, 36'o777777777777);

    reset = 1'b1;
    apply(1);
    for (int e = 1; e <= N; e++) begin
      @(posedge clk);
      cur_edge = e;
      #1;
      if (reset) reset = 1'b0;
      apply(e + 1);
      if (rst_plan[e]) begin
        #2;
        reset = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    chk("rd_q_left", 36'(exp_q.size()), 36'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
